rv32_mod_lsu_split: RTL and testbench

Registered load/store unit between the RV32 hart and the word-wide data bus. It converts byte, half and word requests into aligned 32-bit bus transactions with byte enables, and sign- or zero-extends load data. When enabled, it splits misaligned accesses into two sequential bus beats and merges the results. It reports bus errors, misalignment, illegal size and bus timeout to the hart through a one-cycle response.

---
 rtl/rv32_mod_lsu_split.sv | 241 ++++++++++++++++++++++++
 tb/tb_rv32_mod_lsu_split.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_lsu_split.sv
// RV32 load/store unit: turns byte/half/word hart requests into aligned 32-bit bus beats,
// optionally splitting misaligned accesses into two beats and merging the load result.
module rv32_mod_lsu_split #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int TIMEOUT_CYCLES   = 0,
    parameter int TO_W             = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  req_type,
    input  logic        wr,
    input  logic [31:0] address,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic        stall,
    output logic        data_req,
    output logic        data_wr,
    input  logic        data_ack,
    input  logic        data_err,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_data_o,
    input  logic [31:0] data_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e          state_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic            uns_q;
    logic            wr_q;
    logic            split_q;
    logic [3:0]      be_hi_q;
    logic [31:0]     wdata_hi_q;
    logic [31:0]     lo_data_q;
    logic [TO_W-1:0] cnt_q;

    logic [31:0]     data_o_q;
    logic            valid_q;
    logic            err_q;
    logic [1:0]      err_cause_q;
    logic            data_req_q;
    logic            data_wr_q;
    logic [3:0]      data_be_q;
    logic [31:0]     data_addr_q;
    logic [31:0]     data_data_q;

    logic [3:0]      size_mask_s;
    logic [7:0]      be_ext_s;
    logic [63:0]     wdata_ext_s;
    logic            misaligned_s;
    logic [TO_W-1:0] cnt_inc_s;
    logic            timeout_s;
    logic [31:0]     load_lo_s;
    logic [31:0]     load_hi_s;
    logic [31:0]     load_res_s;
    logic            unused_rsvd_s;

    // Shift the {hi,lo} pair down to the access offset, then extend to 32 bits.
    function automatic logic [31:0] load_ext(
        input logic [31:0] lo,
        input logic [31:0] hi,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] m;
        m = 32'({hi, lo} >> {off, 3'b000});
        case (size)
            2'b00:   load_ext = uns ? {24'h000000, m[7:0]}  : {{24{m[7]}}, m[7:0]};
            2'b01:   load_ext = uns ? {16'h0000, m[15:0]}   : {{16{m[15]}}, m[15:0]};
            default: load_ext = m;
        endcase
    endfunction

    // Byte-lane mask for the requested access size.
    always_comb begin
        size_mask_s = 4'b0000;
        case (req_type[1:0])
            2'b00:   size_mask_s = 4'b0001;
            2'b01:   size_mask_s = 4'b0011;
            2'b10:   size_mask_s = 4'b1111;
            default: size_mask_s = 4'b0000;
        endcase
    end

    // An access is misaligned when it crosses a word boundary.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_type[1:0])
            2'b01:   misaligned_s = (address[1:0] == 2'b11);
            2'b10:   misaligned_s = (address[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

    // Selects the beat data feeding the load merge.
    always_comb begin
        load_lo_s = 32'h0000_0000;
        load_hi_s = 32'h0000_0000;
        if (state_q == ST_LO) begin
            load_lo_s = data_data_i;
            load_hi_s = 32'h0000_0000;
        end else begin
            load_lo_s = lo_data_q;
            load_hi_s = data_data_i;
        end
    end

    // Upper halves of these feed the second beat of a split access.
    assign be_ext_s      = {4'b0000, size_mask_s} << address[1:0];
    assign wdata_ext_s   = {32'h0000_0000, data_i} << {address[1:0], 3'b000};
    assign cnt_inc_s     = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    assign timeout_s     = (TIMEOUT_CYCLES > 0) && (cnt_inc_s == TO_W'(TIMEOUT_CYCLES));
    assign load_res_s    = wr_q ? 32'h0000_0000 : load_ext(load_lo_s, load_hi_s, off_q, size_q, uns_q);
    assign unused_rsvd_s = req_type[2];

    // Access sequencer with registered hart and bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            wr_q        <= 1'b0;
            split_q     <= 1'b0;
            be_hi_q     <= 4'b0000;
            wdata_hi_q  <= 32'h0000_0000;
            lo_data_q   <= 32'h0000_0000;
            cnt_q       <= '0;
            data_o_q    <= 32'h0000_0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= 2'b00;
            data_req_q  <= 1'b0;
            data_wr_q   <= 1'b0;
            data_be_q   <= 4'b0000;
            data_addr_q <= 32'h0000_0000;
            data_data_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req) begin
                        size_q     <= req_type[1:0];
                        uns_q      <= req_type[3];
                        wr_q       <= wr;
                        off_q      <= address[1:0];
                        split_q    <= misaligned_s;
                        be_hi_q    <= be_ext_s[7:4];
                        wdata_hi_q <= wdata_ext_s[63:32];
                        if (req_type[1:0] == 2'b11) begin
                            state_q     <= ST_RESP;
                            err_q       <= 1'b1;
                            err_cause_q <= 2'b00;
                        end else if (misaligned_s && !ALLOW_MISALIGNED) begin
                            state_q     <= ST_RESP;
                            err_q       <= 1'b1;
                            err_cause_q <= 2'b10;
                        end else begin
                            state_q     <= ST_LO;
                            cnt_q       <= '0;
                            data_req_q  <= 1'b1;
                            data_wr_q   <= wr;
                            data_addr_q <= {address[31:2], 2'b00};
                            data_be_q   <= be_ext_s[3:0];
                            data_data_q <= wdata_ext_s[31:0];
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LO, ST_HI: begin
                    if (data_err) begin
                        state_q     <= ST_RESP;
                        data_req_q  <= 1'b0;
                        data_wr_q   <= 1'b0;
                        err_q       <= 1'b1;
                        err_cause_q <= 2'b01;
                    end else if (data_ack) begin
                        if ((state_q == ST_LO) && split_q) begin
                            // Second beat: next word, upper lanes of the shifted request.
                            state_q     <= ST_HI;
                            lo_data_q   <= data_data_i;
                            cnt_q       <= '0;
                            data_addr_q <= {data_addr_q[31:2] + 30'd1, 2'b00};
                            data_be_q   <= be_hi_q;
                            data_data_q <= wdata_hi_q;
                        end else begin
                            state_q    <= ST_RESP;
                            data_req_q <= 1'b0;
                            data_wr_q  <= 1'b0;
                            valid_q    <= 1'b1;
                            data_o_q   <= load_res_s;
                        end
                    end else if (timeout_s) begin
                        state_q     <= ST_RESP;
                        data_req_q  <= 1'b0;
                        data_wr_q   <= 1'b0;
                        err_q       <= 1'b1;
                        err_cause_q <= 2'b11;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_o      = data_o_q;
    assign valid       = valid_q;
    assign err         = err_q;
    assign err_cause   = err_cause_q;
    assign data_req    = data_req_q;
    assign data_wr     = data_wr_q;
    assign data_be     = data_be_q;
    assign data_addr   = data_addr_q;
    assign data_data_o = data_data_q;
    // Combinational so the hart can advance in the response cycle itself.
    assign stall       = !reset && req && !(valid_q || err_q);

endmodule

// File: tb/tb_rv32_mod_lsu_split.sv
// Bench for rv32_mod_lsu_split: vector table with a bus responder, response scoreboard,
// plus hand sequences for reset, mid-beat reset and the no-misaligned build.
module tb_rv32_mod_lsu_split;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  req_type = 4'h0;
    logic        wr = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        valid, err, stall, data_req, data_wr;
    logic [1:0]  err_cause;
    logic        data_ack = 1'b0;
    logic        data_err = 1'b0;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_data_o;
    logic [31:0] data_data_i = 32'h0;

    logic        req2 = 1'b0;
    logic [3:0]  req_type2 = 4'h0;
    logic [31:0] address2 = 32'h0;
    logic [31:0] data_o2;
    logic        valid2, err2, stall2, data_req2, data_wr2;
    logic [1:0]  err_cause2;
    logic [3:0]  data_be2;
    logic [31:0] data_addr2, data_data_o2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rv32_mod_lsu_split #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_type(req_type), .wr(wr),
        .address(address), .data_i(data_i), .data_o(data_o), .valid(valid), .err(err),
        .err_cause(err_cause), .stall(stall), .data_req(data_req), .data_wr(data_wr),
        .data_ack(data_ack), .data_err(data_err), .data_be(data_be), .data_addr(data_addr),
        .data_data_o(data_data_o), .data_data_i(data_data_i)
    );

    rv32_mod_lsu_split #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(0), .TO_W(8)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_type(req_type2), .wr(1'b0),
        .address(address2), .data_i(32'h0), .data_o(data_o2), .valid(valid2), .err(err2),
        .err_cause(err_cause2), .stall(stall2), .data_req(data_req2), .data_wr(data_wr2),
        .data_ack(1'b0), .data_err(1'b0), .data_be(data_be2), .data_addr(data_addr2),
        .data_data_o(data_data_o2), .data_data_i(32'h0)
    );

    typedef struct {
        logic [3:0]  rt;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] bus_lo;
        logic [31:0] bus_hi;
        int          waits;
        int          err_beat;
        logic        silent;
        logic [31:0] a_lo;
        logic [3:0]  be_lo;
        logic [31:0] wd_lo;
        logic [31:0] a_hi;
        logic [3:0]  be_hi;
        logic [31:0] wd_hi;
        logic        exp_err;
        logic [1:0]  exp_cause;
        logic [31:0] exp_do;
        int          exp_lat;
        int          exp_rc;
        int          exp_beats;
    } vec_t;

    typedef struct packed {
        logic        e;
        logic [1:0]  c;
        logic [31:0] d;
    } resp_t;

    resp_t resp_q[$];
    vec_t  vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response scoreboard: every valid/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid || err) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {30'h0, valid, err}, 32'h0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_valid", {31'h0, valid}, {31'h0, !e.e});
                chk("resp_err", {31'h0, err}, {31'h0, e.e});
                if (e.e) chk("resp_cause", {30'h0, err_cause}, {30'h0, e.c});
                else     chk("resp_data", data_o, e.d);
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int lat, rc, stl, wcnt, beat;
        bit done;
        resp_q.push_back('{e: v.exp_err, c: v.exp_cause, d: v.exp_do});
        @(negedge clk);
        req = 1'b1; req_type = v.rt; wr = v.wr; address = v.addr; data_i = v.wd;
        lat = 0; rc = 0; stl = 0; wcnt = 0; beat = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            data_ack = 1'b0;
            data_err = 1'b0;
            if (stall) stl++;
            if (valid || err) begin
                done = 1'b1;
                req = 1'b0;
            end else begin
                if (data_req) begin
                    rc++;
                    if (!v.silent) begin
                        if (wcnt == v.waits) begin
                            chk($sformatf("v%0d_b%0d_addr", idx, beat), data_addr, (beat == 0) ? v.a_lo : v.a_hi);
                            chk($sformatf("v%0d_b%0d_be", idx, beat), {28'h0, data_be}, {28'h0, (beat == 0) ? v.be_lo : v.be_hi});
                            chk($sformatf("v%0d_b%0d_wdata", idx, beat), data_data_o, (beat == 0) ? v.wd_lo : v.wd_hi);
                            chk($sformatf("v%0d_b%0d_wr", idx, beat), {31'h0, data_wr}, {31'h0, v.wr});
                            if (v.err_beat == beat + 1) data_err = 1'b1;
                            else                        data_ack = 1'b1;
                            data_data_i = (beat == 0) ? v.bus_lo : v.bus_hi;
                            beat++;
                            wcnt = 0;
                        end else begin
                            wcnt++;
                        end
                    end
                end
                @(negedge clk);
                lat++;
            end
        end
        data_ack = 1'b0;
        data_err = 1'b0;
        req = 1'b0;
        chk($sformatf("v%0d_done", idx), {31'h0, done}, 32'h1);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_stall_cycles", idx), stl, v.exp_lat);
        chk($sformatf("v%0d_req_cycles", idx), rc, v.exp_rc);
        chk($sformatf("v%0d_beats", idx), beat, v.exp_beats);
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'hDEADBEEF, 2, 1, 1};
        vecs[1]  = '{4'b0000, 1'b0, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'hFFFFFF80, 2, 1, 1};
        vecs[2]  = '{4'b1000, 1'b0, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'h00000080, 2, 1, 1};
        vecs[3]  = '{4'b0010, 1'b0, 32'h102, 32'h0, 32'h11223344, 32'h55667788, 0, 0, 1'b0,
                     32'h100, 4'hC, 32'h0, 32'h104, 4'h3, 32'h0, 1'b0, 2'b00, 32'h77881122, 3, 2, 2};
        vecs[4]  = '{4'b0010, 1'b1, 32'h101, 32'h0A0B0C0D, 32'h0, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'hE, 32'h0B0C0D00, 32'h104, 4'h1, 32'h0000000A, 1'b0, 2'b00, 32'h0, 3, 2, 2};
        vecs[5]  = '{4'b0001, 1'b0, 32'h103, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0,
                     32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 2'b01, 32'h0, 2, 1, 1};
        vecs[6]  = '{4'b0001, 1'b0, 32'h102, 32'h0, 32'h80010000, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'hFFFF8001, 2, 1, 1};
        vecs[7]  = '{4'b1001, 1'b0, 32'h001, 32'h0, 32'h00ABCD00, 32'h0, 0, 0, 1'b0,
                     32'h000, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'h0000ABCD, 2, 1, 1};
        vecs[8]  = '{4'b0011, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1, 0, 0};
        vecs[9]  = '{4'b0010, 1'b0, 32'h104, 32'h0, 32'h12345678, 32'h0, 2, 0, 1'b0,
                     32'h104, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'h12345678, 4, 3, 1};
        vecs[10] = '{4'b0000, 1'b1, 32'h103, 32'h000000A5, 32'h0, 32'h0, 0, 0, 1'b0,
                     32'h100, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0, 1'b0, 2'b00, 32'h0, 2, 1, 1};
        vecs[11] = '{4'b0010, 1'b0, 32'hFFFFFFFE, 32'h0, 32'hAABB0000, 32'h0000CCDD, 0, 0, 1'b0,
                     32'hFFFFFFFC, 4'hC, 32'h0, 32'h0, 4'h3, 32'h0, 1'b0, 2'b00, 32'hCCDDAABB, 3, 2, 2};
        vecs[12] = '{4'b0010, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 2'b11, 32'h0, 5, 4, 0};
        vecs[13] = '{4'b0010, 1'b1, 32'h102, 32'h11223344, 32'h0, 32'h0, 0, 2, 1'b0,
                     32'h100, 4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122, 1'b1, 2'b01, 32'h0, 3, 2, 2};

        // Reset state, with req held high to show stall is forced low.
        req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_data_req", {31'h0, data_req}, 32'h0);
        chk("rst_data_wr", {31'h0, data_wr}, 32'h0);
        chk("rst_valid_err", {30'h0, valid, err}, 32'h0);
        chk("rst_cause", {30'h0, err_cause}, 32'h0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_be", {28'h0, data_be}, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", data_data_o, 32'h0);
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a beat abandons the access without a response.
        begin
            bit saw_resp;
            @(negedge clk);
            req = 1'b1; req_type = 4'b0010; wr = 1'b0; address = 32'h300;
            @(negedge clk);
            chk("midrst_req_up", {31'h0, data_req}, 32'h1);
            reset = 1'b1;
            @(negedge clk);
            chk("midrst_req_down", {31'h0, data_req}, 32'h0);
            chk("midrst_stall", {31'h0, stall}, 32'h0);
            saw_resp = (valid || err);
            reset = 1'b0;
            req = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (valid || err || data_req) saw_resp = 1'b1;
            end
            chk("midrst_no_resp", {31'h0, saw_resp}, 32'h0);
        end

        // Build without misaligned support rejects a crossing half-word, no bus beat.
        begin
            bit saw_req2;
            int lat2;
            saw_req2 = 1'b0;
            lat2 = 0;
            @(negedge clk);
            req2 = 1'b1; req_type2 = 4'b0001; address2 = 32'h103;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                lat2++;
                if (data_req2) saw_req2 = 1'b1;
                if (err2 || valid2) break;
            end
            chk("nomis_err", {31'h0, err2}, 32'h1);
            chk("nomis_valid", {31'h0, valid2}, 32'h0);
            chk("nomis_cause", {30'h0, err_cause2}, 32'h2);
            chk("nomis_latency", lat2, 1);
            chk("nomis_no_bus", {31'h0, saw_req2}, 32'h0);
            req2 = 1'b0;
            repeat (2) @(negedge clk);
        end

        chk("scoreboard_drained", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
